pipeline_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage ARM core; sits beside the ID stage.

---
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard/flush/freeze sequencer for the 5-stage core with
//                saturating performance counters and a sticky mem timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  two_src,
    input  logic                  ignore_hazard,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  forward_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  clear_stats,
    output logic                  hazard,
    output logic                  flush,
    output logic                  freeze_all,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
    output logic [CNT_W-1:0]      mem_wait_cycles
);

    localparam int                  c_WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);

    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_MEM_WAIT = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_timeout_err;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [CNT_W-1:0]    r_memw_cnt;
    logic                w_match1;
    logic                w_match2;
    logic                w_raw;
    logic                w_freeze;
    logic                w_flush;
    logic                w_hazard;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // With forwarding only a load in EXE can still stall the consumer.
    always_comb begin
        w_match1 = (exe_wb_en && (src1 == exe_dest)) || (mem_wb_en && (src1 == mem_dest));
        w_match2 = (exe_wb_en && (src2 == exe_dest)) || (mem_wb_en && (src2 == mem_dest));
        w_raw    = 1'b0;
        if (!ignore_hazard) begin
            if (forward_en) begin
                w_raw = exe_mem_read && exe_wb_en &&
                        ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));
            end else begin
                w_raw = w_match1 || (two_src && w_match2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        w_wait_nxt  = '0;
        if (r_state == c_ST_RUN) begin
            if (mem_req && !mem_ready) begin
                w_freeze    = 1'b1;
                w_state_nxt = c_ST_MEM_WAIT;
            end
        end else begin
            if (mem_ready) begin
                w_state_nxt = c_ST_RUN;
            end else begin
                w_freeze   = 1'b1;
                w_wait_nxt = (r_wait_cnt == c_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
            end
        end
        if (rst) begin
            w_freeze = 1'b0;
        end
        // A branch seen during a freeze simply waits in EXE for release.
        w_flush  = !rst && branch_taken && !w_freeze;
        w_hazard = !rst && w_raw && !branch_taken && !w_freeze;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_memw_cnt    <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == c_WAIT_MAX) begin
                r_timeout_err <= 1'b1;
            end
            if (clear_stats) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
                r_memw_cnt  <= '0;
            end else begin
                r_stall_cnt <= sat_inc(r_stall_cnt, w_hazard);
                r_flush_cnt <= sat_inc(r_flush_cnt, w_flush);
                r_memw_cnt  <= sat_inc(r_memw_cnt, w_freeze);
            end
        end
    end

    assign hazard          = w_hazard;
    assign flush           = w_flush;
    assign freeze_all      = w_freeze;
    assign timeout_err     = r_timeout_err;
    assign stall_cycles    = r_stall_cnt;
    assign flush_events    = r_flush_cnt;
    assign mem_wait_cycles = r_memw_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed and random checks of two differently sized copies
//                of pipeline_hazard_ctrl against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, two_src, ignore_hazard, exe_wb_en, exe_mem_read, mem_wb_en;
    logic       forward_en, branch_taken, mem_req, mem_ready, clear_stats;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       hz0, fl0, fz0, te0, hz1, fl1, fz1, te1;
    logic [1:0] sc0, fc0, mc0;
    logic [4:0] sc1, fc1, mc1;

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(2), .MEM_TIMEOUT(4)) u_dut0 (
        .clk(clk), .rst(rst), .two_src(two_src), .ignore_hazard(ignore_hazard),
        .src1(src1), .src2(src2), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .forward_en(forward_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .clear_stats(clear_stats), .hazard(hz0), .flush(fl0),
        .freeze_all(fz0), .timeout_err(te0), .stall_cycles(sc0), .flush_events(fc0),
        .mem_wait_cycles(mc0)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(5), .MEM_TIMEOUT(20)) u_dut1 (
        .clk(clk), .rst(rst), .two_src(two_src), .ignore_hazard(ignore_hazard),
        .src1(src1), .src2(src2), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .forward_en(forward_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .clear_stats(clear_stats), .hazard(hz1), .flush(fl1),
        .freeze_all(fz1), .timeout_err(te1), .stall_cycles(sc1), .flush_events(fc1),
        .mem_wait_cycles(mc1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state for instance 0 and 1.
    int m_tmo[2] = '{4, 20};
    int m_max[2] = '{3, 31};
    bit m_wait[2];
    bit m_terr[2];
    int m_wcnt[2];
    int m_stall[2];
    int m_flsh[2];
    int m_memw[2];
    bit armed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_raw();
        bit m1, m2;
        if (ignore_hazard) return 1'b0;
        if (forward_en)
            return exe_mem_read && exe_wb_en &&
                   ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));
        m1 = (exe_wb_en && src1 == exe_dest) || (mem_wb_en && src1 == mem_dest);
        m2 = (exe_wb_en && src2 == exe_dest) || (mem_wb_en && src2 == mem_dest);
        return m1 || (two_src && m2);
    endfunction

    function automatic bit exp_freeze(input int i);
        return !rst && (mem_req || m_wait[i]) && !mem_ready;
    endfunction

    function automatic bit exp_flush(input int i);
        return !rst && branch_taken && !exp_freeze(i);
    endfunction

    function automatic bit exp_hazard(input int i);
        return !rst && exp_raw() && !branch_taken && !exp_freeze(i);
    endfunction

    always @(posedge clk) begin : p_model
        bit fz, fl, hz;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_wait[i] = 0; m_terr[i] = 0; m_wcnt[i] = 0;
                m_stall[i] = 0; m_flsh[i] = 0; m_memw[i] = 0;
            end else begin
                fz = exp_freeze(i);
                fl = exp_flush(i);
                hz = exp_hazard(i);
                if (clear_stats) begin
                    m_stall[i] = 0; m_flsh[i] = 0; m_memw[i] = 0;
                end else begin
                    if (hz && m_stall[i] < m_max[i]) m_stall[i]++;
                    if (fl && m_flsh[i]  < m_max[i]) m_flsh[i]++;
                    if (fz && m_memw[i]  < m_max[i]) m_memw[i]++;
                end
                if (m_wait[i] && !mem_ready)
                    m_wcnt[i] = (m_wcnt[i] + 1 > m_tmo[i]) ? m_tmo[i] : m_wcnt[i] + 1;
                else
                    m_wcnt[i] = 0;
                if (m_wcnt[i] == m_tmo[i]) m_terr[i] = 1;
                m_wait[i] = fz;
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("hazard0", hz0, exp_hazard(0));
            chk("flush0", fl0, exp_flush(0));
            chk("freeze0", fz0, exp_freeze(0));
            chk("timeout0", te0, m_terr[0]);
            chk("stall_cnt0", sc0, m_stall[0]);
            chk("flush_cnt0", fc0, m_flsh[0]);
            chk("memw_cnt0", mc0, m_memw[0]);
            chk("hazard1", hz1, exp_hazard(1));
            chk("flush1", fl1, exp_flush(1));
            chk("freeze1", fz1, exp_freeze(1));
            chk("timeout1", te1, m_terr[1]);
            chk("stall_cnt1", sc1, m_stall[1]);
            chk("flush_cnt1", fc1, m_flsh[1]);
            chk("memw_cnt1", mc1, m_memw[1]);
        end
    end

    task automatic idle();
        rst = 0; two_src = 0; ignore_hazard = 0; exe_wb_en = 0; exe_mem_read = 0;
        mem_wb_en = 0; forward_en = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
        clear_stats = 0; src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rdy_pct, clr_pct;
        idle();
        rst = 1; src1 = 3; exe_wb_en = 1; exe_dest = 3;
        tick(); tick();
        chk("rst_stall1", sc1, 0);
        chk("rst_timeout1", te1, 0);
        chk("rst_hazard_forced", hz1, 0);
        chk("rst_freeze0", fz0, 0);
        rst = 0;
        #1 chk("t1_hazard", hz1, 1);
        tick();
        chk("t1_stall_inc", sc1, 1);
        ignore_hazard = 1;
        #1 chk("t1_ignore", hz1, 0);
        tick();
        chk("t1_stall_hold", sc1, 1);

        idle(); forward_en = 1; exe_mem_read = 1; exe_wb_en = 1; exe_dest = 5;
        two_src = 1; src2 = 5; src1 = 0;
        #1 chk("t2_load_use", hz1, 1);
        exe_mem_read = 0;
        #1 chk("t2_no_load", hz1, 0);
        tick();

        idle(); src1 = 3; exe_wb_en = 1; exe_dest = 3; branch_taken = 1;
        #1 chk("t3_flush", fl1, 1);
        chk("t3_hazard_masked", hz1, 0);
        chk("t3_flush_cnt_before", fc1, 0);
        tick();
        chk("t3_flush_cnt", fc1, 1);

        idle(); mem_req = 1; branch_taken = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_freeze", fz1, 1);
            chk("t4_flush_held", fl1, 0);
            tick();
        end
        chk("t4_memw_cnt", mc1, 3);
        mem_ready = 1;
        #1 chk("t4_release_freeze", fz1, 0);
        chk("t4_release_flush", fl1, 1);
        tick();
        chk("t4_flush_cnt", fc1, 2);
        #1 chk("t4_zero_wait", fz1, 0);
        tick();

        idle(); mem_req = 1;
        for (int k = 0; k < 4; k++) tick();
        chk("t5_timeout_early", te0, 0);
        tick();
        chk("t5_timeout_set", te0, 1);
        chk("t5_timeout_other", te1, 0);
        mem_req = 0;
        tick(); tick(); tick();
        chk("t5_still_frozen", fz0, 1);
        mem_ready = 1;
        tick();
        chk("t5_memw_sat", mc0, 3);
        chk("t5_memw_cnt1", mc1, 11);
        clear_stats = 1; mem_ready = 0;
        tick();
        chk("t5_timeout_sticky", te0, 1);
        chk("t5_clear_memw0", mc0, 0);
        chk("t5_clear_memw1", mc1, 0);

        idle(); src1 = 3; exe_wb_en = 1; exe_dest = 3;
        for (int k = 0; k < 5; k++) tick();
        chk("t6_stall_sat", sc0, 3);
        chk("t6_stall_wide", sc1, 5);
        clear_stats = 1;
        #1 chk("t6_hazard_during_clear", hz0, 1);
        tick();
        chk("t6_clear_wins", sc0, 0);
        clear_stats = 0;
        tick();
        chk("t6_stall_restart", sc0, 1);

        idle(); mem_req = 1;
        tick(); tick();
        #1 chk("t6_wait_frozen", fz0, 1);
        rst = 1;
        #1 chk("t6_rst_forces", fz0, 0);
        chk("t6_rst_forces1", fz1, 0);
        tick();
        rst = 0; mem_req = 0;
        #1 chk("t6_rst_to_run", fz0, 0);
        chk("t6_rst_timeout", te0, 0);
        tick();

        for (int ph = 0; ph < 16; ph++) begin
            case (ph % 4)
                0:       rdy_pct = 90;
                1:       rdy_pct = 50;
                2:       rdy_pct = 10;
                default: rdy_pct = 2;
            endcase
            clr_pct = (ph % 3 == 0) ? 5 : 0;
            for (int c = 0; c < 200; c++) begin
                rst           = ($urandom_range(0, 199) == 0);
                two_src       = 1'($urandom_range(0, 1));
                ignore_hazard = ($urandom_range(0, 99) < 15);
                src1          = 4'($urandom_range(0, 3));
                src2          = 4'($urandom_range(0, 3));
                exe_dest      = 4'($urandom_range(0, 3));
                mem_dest      = 4'($urandom_range(0, 3));
                exe_wb_en     = 1'($urandom_range(0, 1));
                mem_wb_en     = 1'($urandom_range(0, 1));
                exe_mem_read  = 1'($urandom_range(0, 1));
                forward_en    = 1'($urandom_range(0, 1));
                branch_taken  = ($urandom_range(0, 99) < 20);
                mem_req       = ($urandom_range(0, 99) < 30);
                mem_ready     = ($urandom_range(0, 99) < rdy_pct);
                clear_stats   = ($urandom_range(0, 99) < clr_pct);
                tick();
            end
        end

        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
